acumulador_muestras: RTL and testbench
======================================

ACUMULADOR_MUESTRAS -- requirements
Module: acumulador_muestras

Interface
REQ-001 Parameter N_MUESTRAS, default 16, samples per block; SHALL be a power of two from 2 to 16.
REQ-002 Parameter LOG2_N, default 4, log2(N_MUESTRAS).
REQ-003 Parameter ANCHO_DATO, default 4, sample width.
REQ-004 clk100MHz  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 SHALL force reset state immediately.
REQ-006 habilitar  in  1  level; 1 enables block accumulation.
REQ-007 dato_adc  in  ANCHO_DATO  sample word from the upstream ADC serial receiver, unsigned.
REQ-008 listo  in  1  upstream sample-ready level, synchronous to clk100MHz, may stay high many cycles.
REQ-009 reconocer  in  1  consumer acknowledge of the held result.
REQ-010 suma  out  ANCHO_DATO+LOG2_N  held block sum.
REQ-011 promedio  out  ANCHO_DATO  held block average.
REQ-012 valido  out  1  level; held result not yet acknowledged.
REQ-013 cuenta  out  LOG2_N  samples accumulated in current block.
REQ-014 desborde  out  1  sticky; a result was overwritten unacknowledged.

Function
REQ-015 A sample SHALL be taken only on a cycle where listo=1 and registered listo_d=0 (rising edge); a high level lasting any number of cycles SHALL count once.
REQ-016 FSM states: INACTIVO, ACUMULA.
REQ-017 INACTIVO: accumulator and cuenta held 0; habilitar=1 -> ACUMULA next cycle; a sample edge in that same cycle SHALL be ignored.
REQ-018 ACUMULA, sample edge, cuenta<N_MUESTRAS-1: acc += dato_adc, cuenta += 1 next cycle.
REQ-019 ACUMULA, sample edge, cuenta=N_MUESTRAS-1: next cycle suma=acc+dato_adc, promedio=that sum >> LOG2_N (truncating), valido=1, acc=0, cuenta=0; state stays ACUMULA.
REQ-020 Result latency SHALL be exactly one cycle after the Nth edge-detect cycle.
REQ-021 Accumulator width ANCHO_DATO+LOG2_N SHALL never wrap (max 16*15=240 fits 8 bits).
REQ-022 ACUMULA, habilitar=0: next cycle INACTIVO, partial block discarded (acc=0, cuenta=0); suma, promedio, valido unaffected.
REQ-023 reconocer=1 while valido=1 and no block completing: valido=0 next cycle; reconocer while valido=0 SHALL have no effect.
REQ-024 Block completing while valido=1 and reconocer=0: suma/promedio overwritten, valido stays 1, desborde=1.
REQ-025 Block completing in same cycle as reconocer=1: new result loaded, valido stays 1, desborde unchanged.
REQ-026 desborde SHALL clear only by reset.
REQ-027 Sample edge and habilitar=0 in the same ACUMULA cycle: sample discarded, REQ-022 applies.

Reset
REQ-028 On reset=0: state INACTIVO, acc=0, cuenta=0, suma=0, promedio=0, valido=0, desborde=0.
REQ-029 listo_d SHALL reset to 1 so listo high at reset release is not counted.
REQ-030 Reset mid-block SHALL discard all partial and held results; next block requires N_MUESTRAS fresh edges.

Structure
REQ-031 Package acumulador_pkg SHALL hold N_MUESTRAS, LOG2_N, ANCHO_DATO defaults and the FSM state encoding.
REQ-032 Sub-module detector_flanco SHALL implement the listo rising-edge detector (REQ-015, REQ-029).

Verification
REQ-033 habilitar=1, 16 samples of 9, listo 1 cycle each -> suma=144, promedio=9, valido=1 one cycle after 16th edge, desborde=0.
REQ-034 Ramp 0..15, listo held 5 cycles per sample -> cuenta steps by 1 per sample, suma=120, promedio=7.
REQ-035 Two blocks of 3 then 5 without reconocer -> after second: suma=80, promedio=5, valido=1, desborde=1; reconocer -> valido=0, desborde stays 1.
REQ-036 7 samples then reset pulse -> all outputs 0; next 16 samples of 15 -> suma=240, promedio=15.
REQ-037 10 samples, habilitar=0 one cycle, habilitar=1, 16 samples of 1 -> suma=16, promedio=1; sample edge on re-enable cycle not counted.
REQ-038 Block completion coincident with reconocer=1 -> valido stays 1, new suma loaded, desborde=0.

Source files
------------

// File: rtl/acumulador_muestras_pkg.sv
// Shared defaults and FSM state encoding for the sample-block accumulator.
// Latency: no logic here (constants only).
// Backpressure: none.
package acumulador_pkg;

  // Parameter defaults picked up by acumulador_muestras.
  localparam int N_MUESTRAS_DEF = 16;
  localparam int LOG2_N_DEF     = 4;
  localparam int ANCHO_DATO_DEF = 4;

  // The FSM has two states, so one bit of encoding is enough.
  localparam logic [0:0] INACTIVO = 1'b0;
  localparam logic [0:0] ACUMULA  = 1'b1;

endpackage

// File: rtl/acumulador_muestras_detector_flanco.sv
// Rising-edge detector for the upstream listo level.
// Latency: the flanco_o pulse is combinational in the cycle where listo rises.
// Backpressure: none. A level held high for many cycles produces one pulse.
// Ports: clk_i clock, rst_ni async active-low reset, listo_i level in,
//        flanco_o one-cycle pulse on the rising edge.
module detector_flanco (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic listo_i,
  output logic flanco_o
);

  logic listo_q;

  // Resetting to 1 keeps a listo level that is already high at reset
  // release from being taken as a fresh sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      listo_q <= 1'b1;
    end else begin
      listo_q <= listo_i;
    end
  end

  assign flanco_o = listo_i & ~listo_q;

endmodule

// File: rtl/acumulador_muestras.sv
// Accumulates blocks of N_MUESTRAS ADC samples and holds their sum and average.
// Latency: the result is registered one cycle after the edge of the Nth sample.
// Backpressure: none. A result that is not acknowledged is overwritten and the
//   sticky desborde flag is set.
// Ports: clk100MHz clock, reset async active-low; habilitar enables blocks;
//        dato_adc/listo carry the sample word and its ready level;
//        reconocer acknowledges the held result; suma/promedio are the held result;
//        valido means the result is not yet acknowledged; cuenta is the number
//        of samples in the current block; desborde means a result was lost.
module acumulador_muestras
  import acumulador_pkg::*;
#(
  parameter int N_MUESTRAS = N_MUESTRAS_DEF,  // power of two, 2..16
  parameter int LOG2_N     = LOG2_N_DEF,
  parameter int ANCHO_DATO = ANCHO_DATO_DEF
) (
  input  logic                       clk100MHz,
  input  logic                       reset,
  input  logic                       habilitar,
  input  logic [ANCHO_DATO-1:0]      dato_adc,
  input  logic                       listo,
  input  logic                       reconocer,
  output logic [ANCHO_DATO+LOG2_N-1:0] suma,
  output logic [ANCHO_DATO-1:0]      promedio,
  output logic                       valido,
  output logic [LOG2_N-1:0]          cuenta,
  output logic                       desborde
);

  localparam int ANCHO_SUMA = ANCHO_DATO + LOG2_N;
  localparam logic [LOG2_N-1:0] ULTIMA = LOG2_N'(N_MUESTRAS - 1);

  logic [0:0]            estado_q, estado_d;
  logic [ANCHO_SUMA-1:0] acc_q, acc_d;
  logic [LOG2_N-1:0]     cuenta_q, cuenta_d;
  logic [ANCHO_SUMA-1:0] suma_q, suma_d;
  logic [ANCHO_DATO-1:0] promedio_q, promedio_d;
  logic                  valido_q, valido_d;
  logic                  desborde_q, desborde_d;

  logic                  flanco;
  logic [ANCHO_SUMA-1:0] suma_nueva;
  logic                  completa;

  detector_flanco u_detector_flanco (
    .clk_i    (clk100MHz),
    .rst_ni   (reset),
    .listo_i  (listo),
    .flanco_o (flanco)
  );

  // The width is log2(N) bits wider than a sample, so a block sum cannot wrap.
  assign suma_nueva = acc_q + ANCHO_SUMA'(dato_adc);

  always_comb begin
    estado_d   = estado_q;
    acc_d      = acc_q;
    cuenta_d   = cuenta_q;
    suma_d     = suma_q;
    promedio_d = promedio_q;
    valido_d   = valido_q;
    desborde_d = desborde_q;
    completa   = 1'b0;

    case (estado_q)
      INACTIVO: begin
        // A sample edge in the enabling cycle is deliberately not counted.
        acc_d    = '0;
        cuenta_d = '0;
        if (habilitar) begin
          estado_d = ACUMULA;
        end
      end
      ACUMULA: begin
        if (!habilitar) begin
          // Drop the partial block. Any held result stays as it is.
          estado_d = INACTIVO;
          acc_d    = '0;
          cuenta_d = '0;
        end else if (flanco) begin
          if (cuenta_q == ULTIMA) begin
            completa   = 1'b1;
            acc_d      = '0;
            cuenta_d   = '0;
            suma_d     = suma_nueva;
            // Divide by N with a truncating shift.
            promedio_d = suma_nueva[ANCHO_SUMA-1:LOG2_N];
          end else begin
            acc_d    = suma_nueva;
            cuenta_d = cuenta_q + LOG2_N'(1);
          end
        end
      end
      default: begin
        estado_d = INACTIVO;
        acc_d    = '0;
        cuenta_d = '0;
      end
    endcase

    // A completing block takes priority over an acknowledge. An acknowledge
    // in the same cycle covers the old result, so desborde is not set.
    if (completa) begin
      valido_d = 1'b1;
      if (valido_q && !reconocer) begin
        desborde_d = 1'b1;
      end
    end else if (reconocer) begin
      valido_d = 1'b0;
    end
  end

  always_ff @(posedge clk100MHz or negedge reset) begin
    if (!reset) begin
      estado_q   <= INACTIVO;
      acc_q      <= '0;
      cuenta_q   <= '0;
      suma_q     <= '0;
      promedio_q <= '0;
      valido_q   <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      acc_q      <= acc_d;
      cuenta_q   <= cuenta_d;
      suma_q     <= suma_d;
      promedio_q <= promedio_d;
      valido_q   <= valido_d;
      desborde_q <= desborde_d;
    end
  end

  assign suma     = suma_q;
  assign promedio = promedio_q;
  assign valido   = valido_q;
  assign cuenta   = cuenta_q;
  assign desborde = desborde_q;

endmodule

// File: tb/tb_acumulador_muestras.sv
// Self-checking bench for acumulador_muestras with default parameters.
// A behavioural model keeps the current block as a queue of samples.
// Directed scenarios are followed by a randomized phase.
module tb_acumulador_muestras;

  logic       clk100MHz = 1'b0;
  logic       reset;
  logic       habilitar;
  logic [3:0] dato_adc;
  logic       listo;
  logic       reconocer;
  logic [7:0] suma;
  logic [3:0] promedio;
  logic       valido;
  logic [3:0] cuenta;
  logic       desborde;

  acumulador_muestras dut (
    .clk100MHz (clk100MHz),
    .reset     (reset),
    .habilitar (habilitar),
    .dato_adc  (dato_adc),
    .listo     (listo),
    .reconocer (reconocer),
    .suma      (suma),
    .promedio  (promedio),
    .valido    (valido),
    .cuenta    (cuenta),
    .desborde  (desborde)
  );

  always #5 clk100MHz = ~clk100MHz;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_en;
  bit m_prev;
  int m_q[$];
  int m_suma;
  int m_prom;
  bit m_val;
  bit m_desb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en   = 1'b0;
    m_prev = 1'b1;
    m_q.delete();
    m_suma = 0;
    m_prom = 0;
    m_val  = 1'b0;
    m_desb = 1'b0;
  endtask

  task automatic model_step(input bit hab, input bit lst, input int d, input bit rec);
    bit edge_s;
    bit done;
    int s;
    edge_s = lst && !m_prev;
    done   = 1'b0;
    m_prev = lst;
    if (!m_en) begin
      m_q.delete();
      m_en = hab;
    end else if (!hab) begin
      m_en = 1'b0;
      m_q.delete();
    end else if (edge_s) begin
      m_q.push_back(d);
      if (m_q.size() == 16) begin
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        if (m_val && !rec) m_desb = 1'b1;
        m_suma = s;
        m_prom = s / 16;
        m_val  = 1'b1;
        done   = 1'b1;
        m_q.delete();
      end
    end
    if (!done && rec) m_val = 1'b0;
  endtask

  task automatic check_all();
    check("suma",     32'(suma),     32'(m_suma));
    check("promedio", 32'(promedio), 32'(m_prom));
    check("valido",   32'(valido),   32'(m_val));
    check("cuenta",   32'(cuenta),   32'(m_q.size()));
    check("desborde", 32'(desborde), 32'(m_desb));
  endtask

  // Drive one cycle (called 1ns after a posedge or mid-cycle), then check after the next posedge.
  task automatic ciclo(input bit hab, input bit lst, input logic [3:0] d, input bit rec);
    habilitar = hab;
    listo     = lst;
    dato_adc  = d;
    reconocer = rec;
    model_step(hab, lst, int'(d), rec);
    @(posedge clk100MHz);
    #1;
    check_all();
  endtask

  task automatic muestra(input logic [3:0] d, input int hold, input bit rec_edge);
    for (int h = 0; h < hold; h++) ciclo(1'b1, 1'b1, d, (h == 0) ? rec_edge : 1'b0);
    ciclo(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic bloque(input logic [3:0] d);
    repeat (16) muestra(d, 1, 1'b0);
  endtask

  task automatic pulso_reset(input bit lst);
    reset = 1'b0;
    listo = lst;
    model_reset();
    #1;
    check("rst_suma",     32'(suma),     32'd0);
    check("rst_promedio", 32'(promedio), 32'd0);
    check("rst_valido",   32'(valido),   32'd0);
    check("rst_cuenta",   32'(cuenta),   32'd0);
    check("rst_desborde", 32'(desborde), 32'd0);
    @(negedge clk100MHz);
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    habilitar = 1'b0;
    listo     = 1'b0;
    dato_adc  = 4'd0;
    reconocer = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clk100MHz);
    reset = 1'b1;

    // Sixteen samples of 9 with a one-cycle listo each
    ciclo(1'b1, 1'b0, 4'd0, 1'b0);
    bloque(4'd9);
    check("b1_suma",     32'(suma),     32'd144);
    check("b1_promedio", 32'(promedio), 32'd9);
    check("b1_valido",   32'(valido),   32'd1);
    check("b1_desborde", 32'(desborde), 32'd0);

    // Ramp 0..15 with listo held for 5 cycles per sample
    ciclo(1'b1, 1'b0, 4'd0, 1'b1);
    check("ack_valido", 32'(valido), 32'd0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      muestra(v, 5, 1'b0);
      check("ramp_cuenta", 32'(cuenta), 32'((i + 1) % 16));
    end
    check("ramp_suma",     32'(suma),     32'd120);
    check("ramp_promedio", 32'(promedio), 32'd7);

    // Two blocks without acknowledge: the second overwrites the first
    ciclo(1'b1, 1'b0, 4'd0, 1'b1);
    bloque(4'd3);
    check("ov1_suma",     32'(suma),     32'd48);
    check("ov1_desborde", 32'(desborde), 32'd0);
    bloque(4'd5);
    check("ov2_suma",     32'(suma),     32'd80);
    check("ov2_promedio", 32'(promedio), 32'd5);
    check("ov2_valido",   32'(valido),   32'd1);
    check("ov2_desborde", 32'(desborde), 32'd1);
    ciclo(1'b1, 1'b0, 4'd0, 1'b1);
    check("ov_ack_valido",   32'(valido),   32'd0);
    check("ov_ack_desborde", 32'(desborde), 32'd1);

    // Reset in the middle of a block; listo stays high across the release
    repeat (7) muestra(4'd6, 1, 1'b0);
    check("mid_cuenta", 32'(cuenta), 32'd7);
    pulso_reset(1'b1);
    ciclo(1'b1, 1'b1, 4'd15, 1'b0);
    ciclo(1'b1, 1'b1, 4'd15, 1'b0);
    check("rel_cuenta", 32'(cuenta), 32'd0);
    ciclo(1'b1, 1'b0, 4'd15, 1'b0);
    bloque(4'd15);
    check("max_suma",     32'(suma),     32'd240);
    check("max_promedio", 32'(promedio), 32'd15);

    // Disable for one cycle after 10 samples; the edge in the re-enable cycle is ignored
    ciclo(1'b1, 1'b0, 4'd0, 1'b1);
    repeat (10) muestra(4'd4, 1, 1'b0);
    ciclo(1'b0, 1'b0, 4'd0, 1'b0);
    check("dis_cuenta", 32'(cuenta), 32'd0);
    ciclo(1'b1, 1'b1, 4'd7, 1'b0);
    check("reen_cuenta", 32'(cuenta), 32'd0);
    ciclo(1'b1, 1'b0, 4'd0, 1'b0);
    bloque(4'd1);
    check("reen_suma",     32'(suma),     32'd16);
    check("reen_promedio", 32'(promedio), 32'd1);

    // The block completes in the same cycle as reconocer
    repeat (15) muestra(4'd2, 1, 1'b0);
    muestra(4'd2, 1, 1'b1);
    check("coin_valido",   32'(valido),   32'd1);
    check("coin_suma",     32'(suma),     32'd32);
    check("coin_desborde", 32'(desborde), 32'd0);

    // Randomized phase
    for (int c = 0; c < 600; c++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      ciclo($urandom_range(0, 24) != 0, $urandom_range(0, 1) == 1, d,
            $urandom_range(0, 11) == 0);
    end
    pulso_reset(1'b0);
    for (int c = 0; c < 300; c++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      ciclo($urandom_range(0, 40) != 0, $urandom_range(0, 2) != 0, d,
            $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
